// File: rtl/speck_round_sequencer.sv
// Iterative SPECK encryption engine: one round of datapath plus key schedule, reused
// ROUNDS times per block, with valid/ready handshakes on the plaintext and ciphertext sides.
module speck_round_sequencer #(
  parameter int WORD   = 16,
  parameter int ROUNDS = 22,
  parameter int ALPHA  = 7,
  parameter int BETA   = 2,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*WORD-1:0]   in_block,
  input  logic [4*WORD-1:0]   in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*WORD-1:0]   out_block,
  output logic                busy,
  output logic [CNT_W-1:0]    round_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  state_e state_q, state_d;

  logic [WORD-1:0]  x_q, x_d;
  logic [WORD-1:0]  y_q, y_d;
  logic [WORD-1:0]  k_q, k_d;
  logic [WORD-1:0]  l0_q, l0_d;
  logic [WORD-1:0]  l1_q, l1_d;
  logic [WORD-1:0]  l2_q, l2_d;
  logic [CNT_W-1:0] round_idx_q, round_idx_d;

  logic            accept;
  logic            last_round;
  logic [WORD-1:0] x_ror, y_rol, l0_ror, k_rol;
  logic [WORD-1:0] x_next, y_next, l_new, k_next;

  // Round datapath; the round consumes k_q before the key schedule replaces it.
  assign x_ror  = {x_q[ALPHA-1:0], x_q[WORD-1:ALPHA]};
  assign y_rol  = {y_q[WORD-BETA-1:0], y_q[WORD-1:WORD-BETA]};
  assign l0_ror = {l0_q[ALPHA-1:0], l0_q[WORD-1:ALPHA]};
  assign k_rol  = {k_q[WORD-BETA-1:0], k_q[WORD-1:WORD-BETA]};

  assign x_next = (x_ror + y_q) ^ k_q;
  assign y_next = y_rol ^ x_next;
  assign l_new  = (k_q + l0_ror) ^ WORD'(round_idx_q);
  assign k_next = k_rol ^ l_new;

  assign accept     = in_valid && in_ready;
  assign last_round = (round_idx_q == LAST_IDX);

  // State register and datapath registers share one synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: every flop uses <= so all registers update from the same pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= '0;
      l0_q        <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      l0_q        <= l0_d;
      l1_q        <= l1_d;
      l2_q        <= l2_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_RUN;
      S_RUN:   if (last_round) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture in IDLE, iterate in RUN, hold otherwise.
  always_comb begin
    // NOTE: defaults to the current value keep every branch fully assigned, so no latch.
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    l0_d        = l0_q;
    l1_d        = l1_q;
    l2_d        = l2_q;
    round_idx_d = round_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d         = in_block[2*WORD-1:WORD];
          y_d         = in_block[WORD-1:0];
          k_d         = in_key[WORD-1:0];
          l0_d        = in_key[2*WORD-1:WORD];
          l1_d        = in_key[3*WORD-1:2*WORD];
          l2_d        = in_key[4*WORD-1:3*WORD];
          round_idx_d = '0;
        end
      end
      S_RUN: begin
        x_d  = x_next;
        y_d  = y_next;
        k_d  = k_next;
        l0_d = l1_q;
        l1_d = l2_q;
        l2_d = l_new;
        if (!last_round) round_idx_d = round_idx_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN);
  end

  assign out_block = {x_q, y_q};
  assign round_idx = round_idx_q;

endmodule
